// File: rtl/dreimann_pkg.sv
// Shared types for the dice button front end.
// FSM state encoding and counter-width helper.
package dreimann_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_A  = 2'd1,
    ST_WAIT_B  = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/button_chord_decoder_if.sv
// Button-in / roll-pulse-out bundle between pins and dice controller.
// master drives the raw buttons, slave is the decoder.
interface button_chord_decoder_if;
  logic btn_a_raw;
  logic btn_b_raw;
  logic roll_a;
  logic roll_b;
  logic roll_both;
  logic busy;

  modport master (
    output btn_a_raw, btn_b_raw,
    input  roll_a, roll_b, roll_both, busy
  );

  modport slave (
    input  btn_a_raw, btn_b_raw,
    output roll_a, roll_b, roll_both, busy
  );
endinterface

// File: rtl/btn_sync_debounce.sv
// 2-FF synchroniser followed by a stable-count debouncer.
// db flips only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
module btn_sync_debounce
  import dreimann_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          s0_q, s1_q;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (s1_q != db_q) begin
      if (cnt_q == CMAX) db_d = ~db_q;
      else cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q  <= 1'b0;
      s1_q  <= 1'b0;
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      s0_q  <= raw;
      s1_q  <= s0_q;
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign db = db_q;

endmodule

// File: rtl/button_chord_decoder.sv
// Classifies debounced A/B presses into roll_a, roll_b or roll_both.
// One registered pulse per gesture; LOCKOUT absorbs until both released.
module button_chord_decoder
  import dreimann_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CHORD_CYCLES    = 2000000
) (
  input  logic clk,
  input  logic rst,
  button_chord_decoder_if.slave bus
);

  localparam int WW = cnt_width(CHORD_CYCLES);
  localparam logic [WW-1:0] WMAX =
    WW'(CHORD_CYCLES - 1);

  logic db_a, db_b;
  logic db_a_p_q, db_b_p_q;
  logic rise_a, rise_b, fall_a, fall_b;

  state_t        state_q, state_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic ra_q, ra_d;
  logic rb_q, rb_d;
  logic rab_q, rab_d;
  logic busy_q, busy_d;

  btn_sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_a (
    .clk(clk), .rst(rst),
    .raw(bus.btn_a_raw), .db(db_a)
  );

  btn_sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_b (
    .clk(clk), .rst(rst),
    .raw(bus.btn_b_raw), .db(db_b)
  );

  assign rise_a = db_a & ~db_a_p_q;
  assign rise_b = db_b & ~db_b_p_q;
  assign fall_a = ~db_a & db_a_p_q;
  assign fall_b = ~db_b & db_b_p_q;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    ra_d    = 1'b0;
    rb_d    = 1'b0;
    rab_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rise_a && rise_b) begin
          rab_d   = 1'b1;
          state_d = ST_LOCKOUT;
        end else if (rise_a) begin
          state_d = ST_WAIT_A;
          wcnt_d  = '0;
        end else if (rise_b) begin
          state_d = ST_WAIT_B;
          wcnt_d  = '0;
        end
      end
      ST_WAIT_A: begin
        if (rise_b) begin
          rab_d   = 1'b1;
          state_d = ST_LOCKOUT;
        end else if (fall_a) begin
          ra_d    = 1'b1;
          state_d = ST_IDLE;
        end else if (wcnt_q == WMAX) begin
          ra_d    = 1'b1;
          state_d = ST_LOCKOUT;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      ST_WAIT_B: begin
        if (rise_a) begin
          rab_d   = 1'b1;
          state_d = ST_LOCKOUT;
        end else if (fall_b) begin
          rb_d    = 1'b1;
          state_d = ST_IDLE;
        end else if (wcnt_q == WMAX) begin
          rb_d    = 1'b1;
          state_d = ST_LOCKOUT;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      ST_LOCKOUT: begin
        if (!db_a && !db_b) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wcnt_q   <= '0;
      db_a_p_q <= 1'b0;
      db_b_p_q <= 1'b0;
      ra_q     <= 1'b0;
      rb_q     <= 1'b0;
      rab_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      db_a_p_q <= db_a;
      db_b_p_q <= db_b;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      rab_q    <= rab_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.roll_a    = ra_q;
  assign bus.roll_b    = rb_q;
  assign bus.roll_both = rab_q;
  assign bus.busy      = busy_q;

endmodule
